// File: rtl/sw_pkg.sv
// Shared constants and types for the Smith-Waterman UART bridge.
// Register map and status bits follow the RS232 core's Avalon slave.
package sw_pkg;
    localparam logic [4:0] ADDR_RX     = 5'd0;
    localparam logic [4:0] ADDR_TX     = 5'd4;
    localparam logic [4:0] ADDR_STATUS = 5'd8;
    localparam int         TX_OK_BIT   = 6;
    localparam int         RX_OK_BIT   = 7;
    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_LEN_ERR  = 8'h01;
    localparam int         TX_FRAME_LEN = 7;

    typedef enum logic [2:0] {
        GET_POLL, GET_BYTE, CHECK, LAUNCH,
        WAIT_CORE, SEND_POLL, SEND_BYTE
    } state_e;

    typedef enum logic [1:0] {
        FLD_REF_LEN, FLD_READ_LEN, FLD_REF, FLD_READ
    } rx_fld_e;

    typedef enum logic {IO_POLL, IO_XFER} io_state_e;

    // Widest per-segment byte count in any frame, plus one.
    function automatic int cnt_width(input int ref_max,
                                     input int read_max);
        int m;
        m = TX_FRAME_LEN;
        if ((ref_max + 3) / 4 > m) m = (ref_max + 3) / 4;
        if ((read_max + 3) / 4 > m) m = (read_max + 3) / 4;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/sw_uart_bridge_if.sv
// Byte-transfer handshake between the frame FSM and the Avalon byte engine.
// grant marks a successful status poll, done marks the data access.
interface sw_uart_bridge_if;
    logic       req;
    logic       dir;
    logic [7:0] wdata;
    logic       grant;
    logic       done;
    logic [7:0] rdata;

    modport master (output req, dir, wdata, input grant, done, rdata);
    modport slave  (input req, dir, wdata, output grant, done, rdata);
endinterface

// File: rtl/sw_avm_byte_io.sv
// Polls STATUS until the needed ok bit is set, then moves one byte.
// Strobes depend only on registered state so they hold under waitrequest.
module sw_avm_byte_io
    import sw_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    sw_uart_bridge_if.slave   bio,
    output logic [4:0]        avm_address,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest
);
    io_state_e  state_q, state_d;
    logic       dir_q, dir_d;
    logic [7:0] wdata_q, wdata_d;
    logic       ok_bit;
    logic       unused_rd;

    assign unused_rd = ^avm_readdata[31:8];

    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        wdata_d       = wdata_q;
        bio.grant     = 1'b0;
        bio.done      = 1'b0;
        bio.rdata     = avm_readdata[7:0];
        avm_address   = ADDR_STATUS;
        avm_read      = 1'b1;
        avm_write     = 1'b0;
        avm_writedata = '0;
        ok_bit = bio.dir ? avm_readdata[TX_OK_BIT]
                         : avm_readdata[RX_OK_BIT];
        unique case (state_q)
            IO_POLL: begin
                if (!avm_waitrequest && bio.req && ok_bit) begin
                    bio.grant = 1'b1;
                    state_d   = IO_XFER;
                    dir_d     = bio.dir;
                    wdata_d   = bio.wdata;
                end
            end
            IO_XFER: begin
                avm_address = dir_q ? ADDR_TX : ADDR_RX;
                avm_read    = !dir_q;
                avm_write   = dir_q;
                if (dir_q) avm_writedata = {24'd0, wdata_q};
                if (!avm_waitrequest) begin
                    bio.done = 1'b1;
                    state_d  = IO_POLL;
                end
            end
            default: state_d = IO_POLL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IO_POLL;
            dir_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: rtl/sw_uart_bridge.sv
// Receives alignment jobs over the RS232 core, launches the SW core,
// and returns a 7-byte result frame for each job.
module sw_uart_bridge
    import sw_pkg::*;
#(
    parameter int REF_MAX_LEN  = 128,
    parameter int READ_MAX_LEN = 128,
    parameter int SCORE_W      = 10
) (
    input  logic                              avm_clk,
    input  logic                              avm_rst_n,
    output logic [4:0]                        avm_address,
    output logic                              avm_read,
    input  logic [31:0]                       avm_readdata,
    output logic                              avm_write,
    output logic [31:0]                       avm_writedata,
    input  logic                              avm_waitrequest,
    output logic                              o_core_valid,
    input  logic                              i_core_ready,
    output logic [2*REF_MAX_LEN-1:0]          o_sequence_ref,
    output logic [2*READ_MAX_LEN-1:0]         o_sequence_read,
    output logic [$clog2(REF_MAX_LEN):0]      o_ref_len,
    output logic [$clog2(READ_MAX_LEN):0]     o_read_len,
    input  logic                              i_core_valid,
    output logic                              o_core_ready,
    input  logic [SCORE_W-1:0]                i_alignment_score,
    input  logic [$clog2(REF_MAX_LEN)-1:0]    i_column,
    input  logic [$clog2(READ_MAX_LEN)-1:0]   i_row,
    output logic [15:0]                       o_job_count
);
    localparam int RL_W  = $clog2(REF_MAX_LEN) + 1;
    localparam int QL_W  = $clog2(READ_MAX_LEN) + 1;
    localparam int CW    = $clog2(REF_MAX_LEN);
    localparam int RW    = $clog2(READ_MAX_LEN);
    localparam int REF_W = 2 * REF_MAX_LEN;
    localparam int QRY_W = 2 * READ_MAX_LEN;
    localparam int CNT_W = cnt_width(REF_MAX_LEN, READ_MAX_LEN);

    function automatic logic [CNT_W-1:0] nbytes(input logic [7:0] len);
        logic [8:0] t;
        t = {1'b0, len} + 9'd3;
        return CNT_W'(t >> 2);
    endfunction

    function automatic logic len_bad(input logic [7:0] len,
                                     input int max);
        return (len == 8'd0) || (int'(len) > max);
    endfunction

    sw_uart_bridge_if bio ();

    sw_avm_byte_io u_io (
        .clk             (avm_clk),
        .rst_n           (avm_rst_n),
        .bio             (bio),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest)
    );

    state_e                    state_q, state_d;
    rx_fld_e                   fld_q, fld_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [7:0]                ref_len_q, ref_len_d;
    logic [7:0]                read_len_q, read_len_d;
    logic [REF_W-1:0]          seq_ref_q, seq_ref_d;
    logic [QRY_W-1:0]          seq_read_q, seq_read_d;
    logic [7:0]                status_q, status_d;
    logic [CW-1:0]             col_q, col_d;
    logic [RW-1:0]             row_q, row_d;
    logic signed [SCORE_W-1:0] score_q, score_d;
    logic [2:0]                tx_idx_q, tx_idx_d;
    logic [15:0]               job_q, job_d;
    logic [15:0]               col16, row16, score16;
    logic [7:0]                tx_byte;

    assign col16   = 16'(col_q);
    assign row16   = 16'(row_q);
    assign score16 = 16'(score_q);

    always_comb begin
        tx_byte = score16[7:0];
        unique case (tx_idx_q)
            3'd0:    tx_byte = status_q;
            3'd1:    tx_byte = col16[15:8];
            3'd2:    tx_byte = col16[7:0];
            3'd3:    tx_byte = row16[15:8];
            3'd4:    tx_byte = row16[7:0];
            3'd5:    tx_byte = score16[15:8];
            default: tx_byte = score16[7:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        fld_d        = fld_q;
        cnt_d        = cnt_q;
        ref_len_d    = ref_len_q;
        read_len_d   = read_len_q;
        seq_ref_d    = seq_ref_q;
        seq_read_d   = seq_read_q;
        status_d     = status_q;
        col_d        = col_q;
        row_d        = row_q;
        score_d      = score_q;
        tx_idx_d     = tx_idx_q;
        job_d        = job_q;
        bio.req      = 1'b0;
        bio.dir      = 1'b0;
        bio.wdata    = tx_byte;
        o_core_valid = 1'b0;
        o_core_ready = 1'b0;
        unique case (state_q)
            GET_POLL: begin
                bio.req = 1'b1;
                if (bio.grant) state_d = GET_BYTE;
            end
            GET_BYTE: begin
                if (bio.done) begin
                    state_d = GET_POLL;
                    unique case (fld_q)
                        FLD_REF_LEN: begin
                            ref_len_d  = bio.rdata;
                            read_len_d = '0;
                            seq_ref_d  = '0;
                            seq_read_d = '0;
                            fld_d      = FLD_READ_LEN;
                        end
                        FLD_READ_LEN: begin
                            read_len_d = bio.rdata;
                            state_d    = CHECK;
                        end
                        FLD_REF: begin
                            seq_ref_d = {seq_ref_q[REF_W-9:0], bio.rdata};
                            cnt_d     = cnt_q - 1'b1;
                            if (cnt_q == CNT_W'(1)) begin
                                fld_d = FLD_READ;
                                cnt_d = nbytes(read_len_q);
                            end
                        end
                        default: begin
                            seq_read_d = {seq_read_q[QRY_W-9:0], bio.rdata};
                            cnt_d      = cnt_q - 1'b1;
                            if (cnt_q == CNT_W'(1)) state_d = LAUNCH;
                        end
                    endcase
                end
            end
            CHECK: begin
                if (len_bad(ref_len_q, REF_MAX_LEN) ||
                    len_bad(read_len_q, READ_MAX_LEN)) begin
                    // Error frames report zero position and score.
                    status_d = ST_LEN_ERR;
                    col_d    = '0;
                    row_d    = '0;
                    score_d  = '0;
                    tx_idx_d = '0;
                    state_d  = SEND_POLL;
                end else begin
                    cnt_d   = nbytes(ref_len_q);
                    fld_d   = FLD_REF;
                    state_d = GET_POLL;
                end
            end
            LAUNCH: begin
                o_core_valid = 1'b1;
                if (i_core_ready) state_d = WAIT_CORE;
            end
            WAIT_CORE: begin
                o_core_ready = 1'b1;
                if (i_core_valid) begin
                    status_d = ST_OK;
                    col_d    = i_column;
                    row_d    = i_row;
                    score_d  = i_alignment_score;
                    tx_idx_d = '0;
                    state_d  = SEND_POLL;
                end
            end
            SEND_POLL: begin
                bio.req = 1'b1;
                bio.dir = 1'b1;
                if (bio.grant) state_d = SEND_BYTE;
            end
            SEND_BYTE: begin
                bio.dir = 1'b1;
                if (bio.done) begin
                    if (tx_idx_q == 3'(TX_FRAME_LEN - 1)) begin
                        job_d   = job_q + 16'd1;
                        fld_d   = FLD_REF_LEN;
                        state_d = GET_POLL;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        state_d  = SEND_POLL;
                    end
                end
            end
            default: state_d = GET_POLL;
        endcase
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            state_q    <= GET_POLL;
            fld_q      <= FLD_REF_LEN;
            cnt_q      <= '0;
            ref_len_q  <= '0;
            read_len_q <= '0;
            seq_ref_q  <= '0;
            seq_read_q <= '0;
            status_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            score_q    <= '0;
            tx_idx_q   <= '0;
            job_q      <= '0;
        end else begin
            state_q    <= state_d;
            fld_q      <= fld_d;
            cnt_q      <= cnt_d;
            ref_len_q  <= ref_len_d;
            read_len_q <= read_len_d;
            seq_ref_q  <= seq_ref_d;
            seq_read_q <= seq_read_d;
            status_q   <= status_d;
            col_q      <= col_d;
            row_q      <= row_d;
            score_q    <= score_d;
            tx_idx_q   <= tx_idx_d;
            job_q      <= job_d;
        end
    end

    assign o_sequence_ref  = seq_ref_q;
    assign o_sequence_read = seq_read_q;
    assign o_ref_len       = RL_W'(ref_len_q);
    assign o_read_len      = QL_W'(read_len_q);
    assign o_job_count     = job_q;
endmodule

// File: tb/tb_sw_uart_bridge.sv
// Bench: RS232 slave model with a frame-level expectation model and
// a toy SW core, plus literal pins for the documented example frames.
module tb_sw_uart_bridge;
    localparam int RMAX = 128;
    localparam int QMAX = 128;

    logic         avm_clk = 1'b0;
    logic         avm_rst_n = 1'b0;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata = '0;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest = 1'b0;
    logic         o_core_valid;
    logic         i_core_ready = 1'b0;
    logic [255:0] o_sequence_ref;
    logic [255:0] o_sequence_read;
    logic [7:0]   o_ref_len;
    logic [7:0]   o_read_len;
    logic         i_core_valid = 1'b0;
    logic         o_core_ready;
    logic [9:0]   i_alignment_score = '0;
    logic [6:0]   i_column = '0;
    logic [6:0]   i_row = '0;
    logic [15:0]  o_job_count;

    sw_uart_bridge #(.REF_MAX_LEN(RMAX), .READ_MAX_LEN(QMAX), .SCORE_W(10)) dut (
        .avm_clk(avm_clk), .avm_rst_n(avm_rst_n),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .o_core_valid(o_core_valid), .i_core_ready(i_core_ready),
        .o_sequence_ref(o_sequence_ref), .o_sequence_read(o_sequence_read),
        .o_ref_len(o_ref_len), .o_read_len(o_read_len),
        .i_core_valid(i_core_valid), .o_core_ready(o_core_ready),
        .i_alignment_score(i_alignment_score), .i_column(i_column),
        .i_row(i_row), .o_job_count(o_job_count)
    );

    always #5 avm_clk = ~avm_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [255:0] rs;
        logic [255:0] qs;
        int rl;
        int ql;
    } launch_t;
    typedef struct { int sc; int col; int row; } res_t;

    byte unsigned rx_q[$];
    byte unsigned exp_tx[$];
    byte unsigned tx_log[$];
    launch_t      exp_l[$];
    res_t         res_q[$];

    int ws = 0, rx_block = 0, tx_got = 0, launches = 0, rx_reads = 0;
    logic [255:0] seen_ref = '0;
    logic [7:0]   seen_rl = '0;

    // Queue one host frame and everything the bridge must do with it.
    task automatic add_frame(input int rl, input int ql,
                             input logic [255:0] rs, input logic [255:0] qs,
                             input int sc, input int col, input int row);
        int nr, nq, s16;
        launch_t l;
        res_t r;
        rx_q.push_back(8'(rl));
        rx_q.push_back(8'(ql));
        if (rl == 0 || rl > RMAX || ql == 0 || ql > QMAX) begin
            exp_tx.push_back(8'h01);
            repeat (6) exp_tx.push_back(8'h00);
            return;
        end
        nr = (rl + 3) / 4;
        nq = (ql + 3) / 4;
        for (int i = nr - 1; i >= 0; i--) rx_q.push_back(rs[8*i +: 8]);
        for (int i = nq - 1; i >= 0; i--) rx_q.push_back(qs[8*i +: 8]);
        l.rs = rs; l.qs = qs; l.rl = rl; l.ql = ql;
        exp_l.push_back(l);
        r.sc = sc; r.col = col; r.row = row;
        res_q.push_back(r);
        s16 = sc & 16'hFFFF;
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'((col >> 8) & 255));
        exp_tx.push_back(8'(col & 255));
        exp_tx.push_back(8'((row >> 8) & 255));
        exp_tx.push_back(8'(row & 255));
        exp_tx.push_back(8'((s16 >> 8) & 255));
        exp_tx.push_back(8'(s16 & 255));
    endtask

    function automatic logic [55:0] pack7(input int s);
        logic [55:0] v;
        v = '1;
        if (tx_log.size() >= s + 7) begin
            v = '0;
            for (int i = 0; i < 7; i++) v = {v[47:0], tx_log[s+i]};
        end
        return v;
    endfunction

    // RS232 slave: sample strobes on negedge, complete on posedge.
    logic        acc_rd = 0, acc_wr = 0, hold = 0;
    logic [4:0]  acc_addr = '0;
    logic [31:0] acc_wd = '0;
    logic [38:0] prev = '0;
    int          wcnt = 0;
    logic        rx_allowed = 0, tx_allowed = 0;

    always @(negedge avm_clk) begin
        acc_rd = avm_read;
        acc_wr = avm_write;
        acc_addr = avm_address;
        acc_wd = avm_writedata;
        if (!avm_rst_n) begin
            wcnt = 0; hold = 0; avm_waitrequest = 1'b0;
            rx_allowed = 0; tx_allowed = 0;
        end else begin
            chk("no_rd_and_wr", acc_rd & acc_wr, 0);
            chk("no_valid_and_ready", o_core_valid & o_core_ready, 0);
            if (hold) chk("strobe_stable", {acc_rd, acc_wr, acc_addr, acc_wd}, prev);
            if ((acc_rd || acc_wr) && wcnt < ws) begin
                avm_waitrequest = 1'b1; wcnt++;
            end else begin
                avm_waitrequest = 1'b0; wcnt = 0;
            end
            hold = avm_waitrequest;
            prev = {acc_rd, acc_wr, acc_addr, acc_wd};
        end
        if (acc_addr == 5'd8)
            avm_readdata = {24'd0, (rx_q.size() > 0 && rx_block == 0), 1'b1, 6'd0};
        else if (acc_addr == 5'd0 && rx_q.size() > 0)
            avm_readdata = {24'd0, rx_q[0]};
        else
            avm_readdata = '0;
    end

    always @(posedge avm_clk) begin
        if (avm_rst_n && !avm_waitrequest) begin
            if (acc_rd && acc_addr == 5'd8) begin
                if (avm_readdata[7]) rx_allowed = 1;
                if (avm_readdata[6]) tx_allowed = 1;
                if (rx_block > 0 && !avm_readdata[7]) rx_block--;
            end else if (acc_rd) begin
                chk("rd_addr", acc_addr, 0);
                chk("rx_after_ok", rx_allowed, 1);
                if (rx_q.size() > 0) void'(rx_q.pop_front());
                rx_allowed = 0;
                rx_reads++;
            end
            if (acc_wr) begin
                chk("wr_addr", acc_addr, 4);
                chk("tx_after_ok", tx_allowed, 1);
                chk("tx_upper_zero", acc_wd[31:8], 0);
                if (exp_tx.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx_unexpected actual=%0h required=none", acc_wd[7:0]);
                end else begin
                    chk("tx_byte", acc_wd[7:0], exp_tx.pop_front());
                end
                tx_log.push_back(acc_wd[7:0]);
                tx_allowed = 0;
                tx_got++;
            end
        end
    end

    // Toy SW core: accepts after a short delay, answers from res_q.
    int vcnt = 0, rcnt = 0;
    always @(negedge avm_clk) begin
        launch_t l;
        res_t r;
        if (!avm_rst_n) begin
            i_core_ready = 0; i_core_valid = 0; vcnt = 0; rcnt = 0;
        end else begin
            if (i_core_ready) begin
                i_core_ready = 0;
                launches++;
                chk("valid_drop", o_core_valid, 0);
            end else if (o_core_valid) begin
                if (vcnt == 2) begin
                    vcnt = 0;
                    i_core_ready = 1;
                    seen_ref = o_sequence_ref;
                    seen_rl = o_ref_len;
                    if (exp_l.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL launch_unexpected actual=1 required=0");
                    end else begin
                        l = exp_l.pop_front();
                        chk("launch_ref", o_sequence_ref, l.rs);
                        chk("launch_read", o_sequence_read, l.qs);
                        chk("launch_ref_len", o_ref_len, l.rl);
                        chk("launch_read_len", o_read_len, l.ql);
                    end
                end else vcnt++;
            end
            if (i_core_valid) begin
                i_core_valid = 0;
                chk("ready_drop", o_core_ready, 0);
            end else if (o_core_ready) begin
                if (rcnt == 1 && res_q.size() > 0) begin
                    rcnt = 0;
                    r = res_q.pop_front();
                    i_alignment_score = 10'(r.sc);
                    i_column = 7'(r.col);
                    i_row = 7'(r.row);
                    i_core_valid = 1;
                end else rcnt++;
            end
        end
    end

    task automatic wait_tx(input int n, input string name);
        int cyc = 0;
        while (tx_got < n && cyc < 3000) begin
            @(posedge avm_clk);
            cyc++;
        end
        checks++;
        if (tx_got < n) begin
            failures++;
            $display("FAIL %s timeout tx_got=%0d required=%0d", name, tx_got, n);
        end
        repeat (3) @(negedge avm_clk);
    endtask

    initial begin
        int base, cyc;
        #1;
        chk("rst_read", avm_read, 1);
        chk("rst_addr", avm_address, 8);
        chk("rst_write", avm_write, 0);
        chk("rst_wdata", avm_writedata, 0);
        chk("rst_cvalid", o_core_valid, 0);
        chk("rst_cready", o_core_ready, 0);
        chk("rst_seq_ref", o_sequence_ref, 0);
        chk("rst_seq_read", o_sequence_read, 0);
        chk("rst_ref_len", o_ref_len, 0);
        chk("rst_job", o_job_count, 0);
        repeat (3) @(negedge avm_clk);
        avm_rst_n = 1'b1;

        add_frame(8, 8, 256'h1B1B, 256'h1B1B, 8, 7, 7);
        wait_tx(7, "t1");
        chk("t1_launches", launches, 1);
        chk("t1_seq_ref_lit", seen_ref[15:0], 16'h1B1B);
        chk("t1_ref_len_lit", seen_rl, 8);
        chk("t1_tx_lit", pack7(0), 56'h00000700070008);
        chk("t1_job", o_job_count, 1);

        add_frame(0, 5, 0, 0, 0, 0, 0);
        wait_tx(14, "t2");
        chk("t2_tx_lit", pack7(7), 56'h01000000000000);
        chk("t2_no_launch", launches, 1);
        chk("t2_job", o_job_count, 2);

        add_frame(5, 3, 256'hA5C3, 256'h6C, -4, 3, 2);
        add_frame(200, 4, 0, 0, 0, 0, 0);
        add_frame(1, 128, 256'h80, {8{32'hDEADBEEF}}, 100, 0, 127);
        wait_tx(35, "t3");
        chk("t3_neg_score_lit", pack7(14), 56'h0000030002FFFC);
        chk("t3_over_max_lit", pack7(21), 56'h01000000000000);
        chk("t3_launches", launches, 3);
        chk("t3_job", o_job_count, 5);

        ws = 3;
        rx_block = 20;
        add_frame(4, 4, 256'h1B, 256'hE4, 5, 1, 1);
        wait_tx(42, "t4");
        chk("t4_block_drained", rx_block, 0);
        chk("t4_launches", launches, 4);
        chk("t4_job", o_job_count, 6);

        ws = 1;
        base = rx_reads;
        rx_q.push_back(8'd8); rx_q.push_back(8'd8);
        rx_q.push_back(8'h12); rx_q.push_back(8'h34);
        rx_q.push_back(8'h56);
        cyc = 0;
        while (rx_reads < base + 5 && cyc < 3000) begin
            @(negedge avm_clk);
            cyc++;
        end
        chk("t5_partial_reads", rx_reads - base, 5);
        @(negedge avm_clk);
        avm_rst_n = 1'b0;
        rx_q.delete(); exp_tx.delete(); exp_l.delete(); res_q.delete();
        #1;
        chk("t5_rst_job", o_job_count, 0);
        chk("t5_rst_seq_ref", o_sequence_ref, 0);
        chk("t5_rst_read", avm_read, 1);
        chk("t5_rst_addr", avm_address, 8);
        repeat (2) @(negedge avm_clk);
        avm_rst_n = 1'b1;
        base = tx_got;
        add_frame(4, 4, 256'h27, 256'h9C, 2, 3, 1);
        wait_tx(base + 7, "t5");
        chk("t5_tx_lit", pack7(base), 56'h00000300010002);
        chk("t5_job", o_job_count, 1);
        chk("t5_launches", launches, 5);

        repeat (20) @(negedge avm_clk);
        chk("end_tx_drained", exp_tx.size(), 0);
        chk("end_launch_drained", exp_l.size(), 0);
        chk("end_no_extra_tx", tx_got, base + 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sw_uart_bridge.md
SW_UART_BRIDGE -- requirements
Module: sw_uart_bridge

Interface
REQ-001 SHALL have parameter REF_MAX_LEN, default 128, maximum reference length in bases.
REQ-002 SHALL have parameter READ_MAX_LEN, default 128, maximum read length in bases.
REQ-003 SHALL have parameter SCORE_W, default 10, alignment score width, signed.
REQ-004 SHALL have port avm_clk  in  1  single clock for all logic.
REQ-005 SHALL have port avm_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports avm_address out 5, avm_read out 1, avm_readdata in 32, avm_write out 1, avm_writedata out 32, avm_waitrequest in 1: Avalon-MM master to the RS232 core. RX=0, TX=4, STATUS=8; TX_OK bit 6, RX_OK bit 7.
REQ-007 SHALL have ports o_core_valid out 1, i_core_ready in 1: job handshake toward the SW core.
REQ-008 SHALL have ports o_sequence_ref out 2*REF_MAX_LEN, o_sequence_read out 2*READ_MAX_LEN, o_ref_len out clog2(REF_MAX_LEN)+1, o_read_len out clog2(READ_MAX_LEN)+1.
REQ-009 SHALL have ports i_core_valid in 1, o_core_ready out 1, i_alignment_score in SCORE_W, i_column in clog2(REF_MAX_LEN), i_row in clog2(READ_MAX_LEN): result handshake.
REQ-010 SHALL have port o_job_count out 16: count of completed response frames, wraps at 0xFFFF->0.

Function
REQ-011 SHALL use states GET_POLL, GET_BYTE, CHECK, LAUNCH, WAIT_CORE, SEND_POLL, SEND_BYTE.
REQ-012 Poll: SHALL hold avm_read=1 at STATUS until avm_waitrequest=0; sample the required ok bit that cycle; if clear, re-poll; if set, next cycle issue the data access.
REQ-013 SHALL never assert avm_read and avm_write together; SHALL hold address/strobe/data stable while avm_waitrequest=1.
REQ-014 RX frame SHALL be: byte0 ref_len, byte1 read_len, then ceil(ref_len/4) ref bytes, then ceil(read_len/4) read bytes; 4 bases per byte, first base in bits[7:6].
REQ-015 Each data byte SHALL shift into the LSB end of its sequence register; register zeroed at frame start, so sequences are right-aligned with zero upper bits.
REQ-016 CHECK SHALL occur after byte1: length 0 or > max is an error; on error SHALL skip sequence bytes and go directly to SEND_POLL with status 0x01.
REQ-017 LAUNCH SHALL assert o_core_valid with stable sequence/length outputs until the cycle i_core_ready=1, then deassert next cycle.
REQ-018 WAIT_CORE SHALL assert o_core_ready; capture score/column/row on the cycle i_core_valid=1; o_core_ready=0 in every other state.
REQ-019 TX frame SHALL be 7 bytes: status, column[15:8], column[7:0], row[15:8], row[7:0], score[15:8], score[7:0]; fields zero-extended (score sign-extended) to 16 bits; error frames carry six zero bytes.
REQ-020 Each TX byte SHALL be written on avm_writedata[7:0], bits[31:8]=0, only after a TX_OK poll.
REQ-021 After the 7th byte is accepted SHALL increment o_job_count and return to GET_POLL; back-to-back frames SHALL need no idle gap.
REQ-022 Byte counters SHALL be sized for max(ceil(REF_MAX_LEN/4), ceil(READ_MAX_LEN/4), 7) and never wrap inside a frame.

Reset
REQ-023 On avm_rst_n=0 SHALL immediately: state GET_POLL, avm_read=1, avm_address=STATUS, avm_write=0, avm_writedata=0, o_core_valid=0, o_core_ready=0, sequences/lengths/captured results=0, o_job_count=0.
REQ-024 Reset mid-frame SHALL discard partial data; the next byte after release is byte0 of a new frame.

Structure
REQ-025 Package sw_pkg SHALL hold register offsets, status bit indices, status codes (0x00 OK, 0x01 LEN_ERR), TX frame length, state enum.
REQ-026 Sub-module sw_avm_byte_io SHALL implement poll-then-transfer of one byte (req/done handshake, dir bit); the FSM sequences frames over it.

Verification
REQ-027 ref_len=8, read_len=8, ref 0x1B 0x1B, read 0x1B 0x1B -> o_sequence_ref[15:0]=0x1B1B, o_ref_len=8, one o_core_valid pulse.
REQ-028 Core returns score=8, column=7, row=7 -> TX 00 00 07 00 07 00 08, o_job_count=1.
REQ-029 ref_len=0 -> no core launch, TX 01 00 00 00 00 00 00.
REQ-030 Score=-4 (SCORE_W=10) -> last two TX bytes FF FC.
REQ-031 STATUS RX_OK clear for 20 polls, waitrequest high 3 cycles per access -> no RX read until bit set, strobes stable, frame still correct.
REQ-032 Reset asserted after 5 RX bytes, then full ref_len=4/read_len=4 frame -> correct single response, o_job_count=1.
